// File: rtl/instr_assembler_if.sv
// Instruction-assembler bus: field input handshake, instruction-memory
// write port and session status, bundled so producer and consumer share
// one definition.
interface instr_assembler_if #(
  parameter int INSTR_LEN = 32
);
  logic                 start;
  logic [63:0]          base_addr;
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_fmt;
  logic [10:0]          in_opcode;
  logic [4:0]           in_rm;
  logic [5:0]           in_shamt;
  logic [8:0]           in_address;
  logic [4:0]           in_rn;
  logic [4:0]           in_rd;
  logic                 in_last;
  logic                 imem_we;
  logic [63:0]          imem_addr;
  logic [INSTR_LEN-1:0] imem_wdata;
  logic [15:0]          count;
  logic                 busy;
  logic                 done;
  logic                 err;

  // Producer side: issues sessions and instruction fields.
  modport master (
    output start, base_addr, in_valid, in_fmt, in_opcode, in_rm, in_shamt,
           in_address, in_rn, in_rd, in_last,
    input  in_ready, imem_we, imem_addr, imem_wdata, count, busy, done, err
  );

  // Assembler side: accepts fields, writes encoded words.
  modport slave (
    input  start, base_addr, in_valid, in_fmt, in_opcode, in_rm, in_shamt,
           in_address, in_rn, in_rd, in_last,
    output in_ready, imem_we, imem_addr, imem_wdata, count, busy, done, err
  );
endinterface

// File: rtl/instr_assembler.sv
// Instruction assembler: encodes R-type / D-type fields into instruction
// words and writes them to consecutive instruction-memory addresses
// starting at a per-session base address.
module instr_assembler #(
  parameter int DEPTH     = 64,
  parameter int INSTR_LEN = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_assembler_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [15:0] DEPTH_CNT = 16'(DEPTH);

  state_t      state;
  logic [63:0] ptr;     // byte address of the next word to write
  logic [31:0] word;    // encoded form of the fields on the bus
  logic        accept;

  assign accept = bus.in_valid && bus.in_ready;

  // Encode the presented fields; fields unused by the format never reach the word.
  always_comb begin
    // NOTE: default first so every path assigns word and no latch is inferred.
    word = '0;
    if (bus.in_fmt) begin
      word = {bus.in_opcode, bus.in_address, 2'b00, bus.in_rn, bus.in_rd};
    end else begin
      word = {bus.in_opcode, bus.in_rm, bus.in_shamt, bus.in_rn, bus.in_rd};
    end
  end

  // Session FSM with registered handshake, write port and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      ptr            <= '0;
      bus.in_ready   <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      bus.count      <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      bus.imem_we <= 1'b0;
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            state        <= LOAD;
            ptr          <= bus.base_addr;
            bus.count    <= '0;
            bus.err      <= 1'b0;
            bus.in_ready <= 1'b1;
            bus.busy     <= 1'b1;
          end
        end
        LOAD: begin
          if (accept) begin
            if (bus.count == DEPTH_CNT) begin
              // Session already full: drop the beat and end with an error.
              bus.err      <= 1'b1;
              bus.done     <= 1'b1;
              bus.in_ready <= 1'b0;
              state        <= DONE;
            end else begin
              bus.imem_we    <= 1'b1;
              bus.imem_addr  <= ptr;
              bus.imem_wdata <= INSTR_LEN'(word);
              ptr            <= ptr + 64'd4;  // wraps modulo 2^64
              bus.count      <= bus.count + 16'd1;
              if (bus.in_last) begin
                bus.in_ready <= 1'b0;
                state        <= DRAIN;
              end
            end
          end
        end
        DRAIN: begin
          // The final write is on the port this cycle.
          bus.done <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.in_ready <= 1'b0;
          bus.busy     <= 1'b0;
          bus.done     <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule
